alu_control_sequencer: RTL

Hard-wired control unit driving the datapath's bus-enable, register-load and ALU-select strobes. It sequences instruction fetch (T0–T2) and execution (T3–T6) of register-to-register ALU instructions, including mul/div results into LO/HI. It sits directly upstream of the datapath, reads the IR contents back from it, and replaces hand-driven testbench stimulus.

---
 rtl/alu_control_sequencer.sv | 128 ++++++++++++
 1 files changed

// File: rtl/alu_control_sequencer.sv
// rtl/alu_control_sequencer.sv - hard-wired fetch/execute control sequencer for register ALU instructions
// Moore control unit: strobes decode from the state register and the IR read back from the datapath.
module alu_control_sequencer #(
   parameter logic [4:0] INC_OP = 5'd12,
   parameter int         IR_W   = 32
) (
   input  logic            clk,
   input  logic            clr,
   input  logic            run,
   input  logic [IR_W-1:0] ir,
   output logic            PCout,
   output logic            Zlowout,
   output logic            Zhighout,
   output logic            MDRout,
   output logic            MARin,
   output logic            Zin,
   output logic            PCin,
   output logic            MDRin,
   output logic            IRin,
   output logic            Yin,
   output logic            LOin,
   output logic            HIin,
   output logic            Read,
   output logic [15:0]     Rin,
   output logic [15:0]     Rout,
   output logic [4:0]      alu_op,
   output logic            instr_done,
   output logic            halted
);

   typedef enum logic [3:0] {
      S_IDLE, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_HALT
   } state_t;

   typedef enum logic [2:0] {
      C_BIN, C_UN, C_MULDIV, C_NOP, C_ILL
   } cls_t;

   state_t     state, state_next;
   cls_t       cls;
   logic [4:0] opcode, op_code;
   logic [3:0] ra, rb, rc;
   logic       unused_ir;

   assign opcode    = ir[31:27];
   assign ra        = ir[26:23];
   assign rb        = ir[22:19];
   assign rc        = ir[18:15];
   assign unused_ir = ^ir[14:0];

   always_comb begin
      op_code = 5'd0;
      cls     = C_ILL;
      case (opcode)
         5'b00011: begin op_code = 5'd0;  cls = C_BIN;    end
         5'b00100: begin op_code = 5'd1;  cls = C_BIN;    end
         5'b00101: begin op_code = 5'd2;  cls = C_BIN;    end
         5'b00110: begin op_code = 5'd3;  cls = C_BIN;    end
         5'b00111: begin op_code = 5'd4;  cls = C_BIN;    end
         5'b01000: begin op_code = 5'd5;  cls = C_BIN;    end
         5'b01001: begin op_code = 5'd6;  cls = C_BIN;    end
         5'b01010: begin op_code = 5'd7;  cls = C_BIN;    end
         5'b01011: begin op_code = 5'd8;  cls = C_BIN;    end
         5'b01111: begin op_code = 5'd9;  cls = C_MULDIV; end
         5'b10000: begin op_code = 5'd10; cls = C_MULDIV; end
         5'b10001: begin op_code = 5'd11; cls = C_UN;     end
         5'b10010: begin op_code = 5'd13; cls = C_UN;     end
         5'b11010: begin op_code = 5'd0;  cls = C_NOP;    end
         default:  begin op_code = 5'd0;  cls = C_ILL;    end
      endcase
   end

   always_ff @(posedge clk) begin
      if (clr) state <= S_IDLE;
      else     state <= state_next;
   end

   // An instruction always completes; run only matters at its boundary.
   always_comb begin
      state_next = state;
      case (state)
         S_IDLE: state_next = run ? S_T0 : S_IDLE;
         S_T0:   state_next = S_T1;
         S_T1:   state_next = S_T2;
         S_T2:   state_next = (cls == C_NOP) ? (run ? S_T0 : S_IDLE) : S_T3;
         S_T3:   state_next = (cls == C_ILL) ? S_HALT : S_T4;
         S_T4:   state_next = S_T5;
         S_T5:   state_next = (cls == C_MULDIV) ? S_T6 : (run ? S_T0 : S_IDLE);
         S_T6:   state_next = run ? S_T0 : S_IDLE;
         S_HALT: state_next = S_HALT;
         default: state_next = S_IDLE;
      endcase
   end

   always_comb begin
      PCout = 1'b0; Zlowout = 1'b0; Zhighout = 1'b0; MDRout = 1'b0;
      MARin = 1'b0; Zin = 1'b0; PCin = 1'b0; MDRin = 1'b0; IRin = 1'b0;
      Yin = 1'b0; LOin = 1'b0; HIin = 1'b0; Read = 1'b0;
      Rin = 16'h0000; Rout = 16'h0000; alu_op = 5'd0;
      instr_done = 1'b0; halted = 1'b0;
      case (state)
         S_T0: begin PCout = 1'b1; MARin = 1'b1; Zin = 1'b1; alu_op = INC_OP; end
         S_T1: begin Zlowout = 1'b1; PCin = 1'b1; Read = 1'b1; MDRin = 1'b1; end
         S_T2: begin MDRout = 1'b1; IRin = 1'b1; instr_done = (cls == C_NOP); end
         S_T3: begin
            if (cls == C_BIN || cls == C_UN) begin Rout = 16'h1 << rb; Yin = 1'b1; end
            else if (cls == C_MULDIV)        begin Rout = 16'h1 << ra; Yin = 1'b1; end
         end
         S_T4: begin
            if (cls == C_BIN || cls == C_UN || cls == C_MULDIV) begin
               Rout   = 16'h1 << ((cls == C_BIN) ? rc : rb);
               alu_op = op_code;
               Zin    = 1'b1;
            end
         end
         S_T5: begin
            if (cls == C_MULDIV) begin Zlowout = 1'b1; LOin = 1'b1; end
            else if (cls == C_BIN || cls == C_UN) begin
               Zlowout = 1'b1; Rin = 16'h1 << ra; instr_done = 1'b1;
            end
         end
         S_T6:   begin Zhighout = 1'b1; HIin = 1'b1; instr_done = 1'b1; end
         S_HALT: halted = 1'b1;
         default: ;
      endcase
   end

endmodule
